// File: rtl/adder24_pkg.sv
// Shared constants, types and helpers for the 24-bit segmented adder front end.
// The carry chain is split into NSEG segments of SEG_W bits each.
package adder24_pkg;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned SEG_W = 3;
    localparam int unsigned NSEG  = WIDTH / SEG_W;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [NSEG-1:0]  segflag_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        word_t    s;
        word_t    d;
        logic     c0;
        segflag_t px;
    } pg_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(pg_payload_t);

    // A segment may be skipped only when every bit in it propagates.
    function automatic segflag_t seg_all_prop(input word_t p);
        segflag_t flags;
        flags = {NSEG{1'b0}};
        for (int unsigned i = 0; i < NSEG; i++) begin
            flags[i] = &p[i*SEG_W +: SEG_W];
        end
        return flags;
    endfunction

endpackage

// File: rtl/adder24_pg_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the outputs,
// skid register catches the beat accepted while downstream stalls.
module pg_skid_buf
    import adder24_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    state_t        state_r;
    logic [DW-1:0] main_r;
    logic [DW-1:0] skid_r;
    logic          out_valid_r;
    logic          in_ready_r;
    logic          in_xfer_s;
    logic          out_xfer_s;

    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;

    // Occupancy FSM; in_ready is registered so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            main_r      <= {DW{1'b0}};
            skid_r      <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_r      <= in_data;
                        out_valid_r <= 1'b1;
                        state_r     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_r <= in_data;
                    end else if (in_xfer_s) begin
                        skid_r     <= in_data;
                        in_ready_r <= 1'b0;
                        state_r    <= FULL;
                    end else if (out_xfer_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer_s) begin
                        main_r     <= skid_r;
                        in_ready_r <= 1'b1;
                        state_r    <= ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty buffer.
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

endmodule

// File: rtl/adder24_pg_stage.sv
// Registered propagate/generate front end for the 24-bit segmented carry chain.
// Computes S/DI/carry-in/skip flags and presents them through a skid buffer.
module adder24_pg_stage
    import adder24_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  word_t    a,
    input  word_t    b,
    input  logic     sub,
    output logic     out_valid,
    input  logic     out_ready,
    output word_t    s,
    output word_t    d,
    output logic     c0,
    output segflag_t px
);

    word_t                bb_s;
    pg_payload_t          pg_s;
    logic [PAYLOAD_W-1:0] buf_out_s;
    pg_payload_t          pg_out_s;

    // Subtraction is a + ~b + 1, the +1 entering as the chain carry-in.
    always_comb begin
        bb_s  = {WIDTH{1'b0}};
        pg_s  = '{s: {WIDTH{1'b0}}, d: {WIDTH{1'b0}}, c0: 1'b0, px: {NSEG{1'b0}}};
        if (sub) begin
            bb_s = ~b;
        end else begin
            bb_s = b;
        end
        pg_s.s  = a ^ bb_s;
        pg_s.d  = a;
        pg_s.c0 = sub;
        pg_s.px = seg_all_prop(a ^ bb_s);
    end

    pg_skid_buf #(
        .DW (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pg_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out_s)
    );

    assign pg_out_s = pg_payload_t'(buf_out_s);
    assign s        = pg_out_s.s;
    assign d        = pg_out_s.d;
    assign c0       = pg_out_s.c0;
    assign px       = pg_out_s.px;

endmodule

// File: tb/tb_adder24_pg_stage.sv
// Self-checking bench: randomized and directed beats against a FIFO scoreboard
// whose entries are derived arithmetically from the operands.
module tb_adder24_pg_stage;
    import adder24_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     in_valid = 1'b0;
    logic     in_ready;
    word_t    a = 24'h000000;
    word_t    b = 24'h000000;
    logic     sub = 1'b0;
    logic     out_valid;
    logic     out_ready = 1'b0;
    word_t    s;
    word_t    d;
    logic     c0;
    segflag_t px;

    int n_checks = 0;
    int n_errors = 0;

    logic [56:0] exp_q[$];
    word_t       sum_q[$];

    adder24_pg_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .d         (d),
        .c0        (c0),
        .px        (px)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected payload: a bit propagates when a differs from the effective b bit.
    function automatic logic [56:0] ref_payload(input word_t ai, input word_t bi, input logic si);
        word_t    eff_b;
        word_t    pv;
        segflag_t skip;
        eff_b = si ? (24'hFFFFFF - bi) : bi;
        for (int i = 0; i < 24; i++) pv[i] = (ai[i] != eff_b[i]);
        for (int k = 0; k < 8; k++) skip[k] = (pv[k*3] && pv[k*3+1] && pv[k*3+2]);
        return {pv, ai, si, skip};
    endfunction

    // Ripple the payload through an ideal carry-mux chain to recover the sum.
    function automatic word_t chain_sum(input logic [56:0] p);
        word_t sv;
        word_t dv;
        word_t sum;
        logic  carry;
        sv    = p[56:33];
        dv    = p[32:9];
        carry = p[8];
        for (int i = 0; i < 24; i++) begin
            sum[i] = sv[i] ^ carry;
            carry  = sv[i] ? carry : dv[i];
        end
        return sum;
    endfunction

    task automatic step(input logic iv, input word_t ai, input word_t bi,
                        input logic si, input logic ordy);
        logic [56:0] obs;
        in_valid  = iv;
        a         = ai;
        b         = bi;
        sub       = si;
        out_ready = ordy;
        obs       = {s, d, c0, px};
        check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        if (out_valid && exp_q.size() != 0) begin
            check_eq("payload", 64'(obs), 64'(exp_q[0]));
            check_eq("chain_sum", 64'(chain_sum(obs)), 64'(sum_q[0]));
            if (ordy) begin
                void'(exp_q.pop_front());
                void'(sum_q.pop_front());
            end
        end
        if (iv && in_ready) begin
            exp_q.push_back(ref_payload(ai, bi, si));
            sum_q.push_back(si ? word_t'(ai - bi) : word_t'(ai + bi));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) step(1'b0, 24'h0, 24'h0, 1'b0, 1'b1);
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_s_d_c0_px"}, 64'({s, d, c0, px}), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        check_reset_outputs("after_reset");

        step(1'b1, 24'h000001, 24'h000001, 1'b0, 1'b1);
        check_eq("add_valid", 64'(out_valid), 64'd1);
        check_eq("add_s", 64'(s), 64'h000000);
        check_eq("add_d", 64'(d), 64'h000001);
        check_eq("add_c0", 64'(c0), 64'd0);
        check_eq("add_px", 64'(px), 64'h00);

        step(1'b1, 24'h000005, 24'h000003, 1'b1, 1'b1);
        check_eq("sub_s", 64'(s), 64'hFFFFF9);
        check_eq("sub_d", 64'(d), 64'h000005);
        check_eq("sub_c0", 64'(c0), 64'd1);
        check_eq("sub_px", 64'(px), 64'hFE);

        step(1'b1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1);
        check_eq("fullprop_s", 64'(s), 64'hFFFFFF);
        check_eq("fullprop_d", 64'(d), 64'hFFFFFF);
        check_eq("fullprop_px", 64'(px), 64'hFF);

        step(1'b1, 24'h123456, 24'h000000, 1'b1, 1'b1);
        check_eq("subzero_s", 64'(s), 64'hEDCBA9);
        check_eq("subzero_c0", 64'(c0), 64'd1);
        drain();

        // Backpressure: A and B accepted, C held until the stall clears.
        step(1'b1, 24'h00000A, 24'h000001, 1'b0, 1'b0);
        step(1'b1, 24'h00000B, 24'h000002, 1'b1, 1'b0);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 24'h00000C, 24'h000003, 1'b0, 1'b0);
        step(1'b1, 24'h00000C, 24'h000003, 1'b0, 1'b1);
        step(1'b1, 24'h00000C, 24'h000003, 1'b0, 1'b1);
        step(1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1);
        check_eq("bp_drained", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 16; i++) step(1'b1, word_t'(i), 24'h000010, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), word_t'($urandom), word_t'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Asynchronous reset while the buffer is full.
        step(1'b1, 24'h111111, 24'h222222, 1'b0, 1'b0);
        step(1'b1, 24'h333333, 24'h044444, 1'b1, 1'b0);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        sum_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 24'h00ABCD, 24'h000111, 1'b0, 1'b1);
        check_eq("post_reset_valid", 64'(out_valid), 64'd1);
        check_eq("post_reset_s", 64'(s), 64'h00AADC);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
